// File: rtl/cc_demux_pkg.sv
// Shared constants and the select-to-write-enable decoder for the 8-channel demux writer.
// Imported by cc_demux_channel_writer and cc_demux_channel_slot.
package cc_demux_pkg;

    localparam int CC_DEMUX_SEL_WIDTH = 3;
    localparam int CC_DEMUX_CHANNELS  = 2 ** CC_DEMUX_SEL_WIDTH;

    typedef logic [CC_DEMUX_SEL_WIDTH-1:0] sel_t;
    typedef logic [CC_DEMUX_CHANNELS-1:0]  chan_mask_t;

    // Channel index to one-hot write-enable vector.
    function automatic chan_mask_t onehot_decode(input sel_t sel);
        chan_mask_t mask;
        mask      = '0;
        mask[sel] = 1'b1;
        return mask;
    endfunction

endpackage

// File: rtl/cc_demux_channel_slot.sv
// One registered channel slot: a data register plus a full flag.
// A write wins over a same-cycle ack; an ack alone clears the flag but keeps the data.
module cc_demux_channel_slot
    import cc_demux_pkg::*;
#(
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          we,
    input  logic          ack,
    input  logic [DW-1:0] wr_data,
    output logic [DW-1:0] data,
    output logic          valid
);

    // NOTE: state updates use non-blocking assignments, and the data register is
    // reset explicitly because downstream selection logic expects zeros after reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            data  <= '0;
            valid <= 1'b0;
        end else if (we) begin
            data  <= wr_data;
            valid <= 1'b1;
        end else if (ack) begin
            valid <= 1'b0;
        end
    end

endmodule

// File: rtl/cc_demux_channel_writer.sv
// Routes one write bus into one of 8 registered channel slots with valid/ready back-pressure.
// Define CC_DEMUX_OVERWRITE_EN to drop back-pressure and add a sticky overflow flag instead.
module cc_demux_channel_writer
    import cc_demux_pkg::*;
#(
    parameter int DATAWIDTH_BUS           = 8,
    parameter int DATAWIDTH_MUX_SELECTION = CC_DEMUX_SEL_WIDTH,
    parameter int DATAWIDTH_COUNT         = 8
) (
    input  logic                               CC_DEMUX_CLOCK_50,
    input  logic                               CC_DEMUX_RESET_InLow,
    input  logic [DATAWIDTH_BUS-1:0]           CC_DEMUX_data_InBUS,
    input  logic [DATAWIDTH_MUX_SELECTION-1:0] CC_DEMUX_selection_InBUS,
    input  logic                               CC_DEMUX_valid_In,
    output logic                               CC_DEMUX_ready_Out,
    input  logic [CC_DEMUX_CHANNELS-1:0]       CC_DEMUX_ack_InBUS,
    output logic [DATAWIDTH_BUS-1:0]           CC_DEMUX_data0_OutBUS,
    output logic [DATAWIDTH_BUS-1:0]           CC_DEMUX_data1_OutBUS,
    output logic [DATAWIDTH_BUS-1:0]           CC_DEMUX_data2_OutBUS,
    output logic [DATAWIDTH_BUS-1:0]           CC_DEMUX_data3_OutBUS,
    output logic [DATAWIDTH_BUS-1:0]           CC_DEMUX_data4_OutBUS,
    output logic [DATAWIDTH_BUS-1:0]           CC_DEMUX_data5_OutBUS,
    output logic [DATAWIDTH_BUS-1:0]           CC_DEMUX_data6_OutBUS,
    output logic [DATAWIDTH_BUS-1:0]           CC_DEMUX_data7_OutBUS,
    output logic [CC_DEMUX_CHANNELS-1:0]       CC_DEMUX_valid_OutBUS,
`ifdef CC_DEMUX_OVERWRITE_EN
    output logic                               CC_DEMUX_overflow_Out,
`endif
    output logic [DATAWIDTH_COUNT-1:0]         CC_DEMUX_count_OutBUS
);

    logic                     clk;
    logic                     rst_n;
    sel_t                     sel;
    logic                     sel_known;
    logic                     accept;
    chan_mask_t               we;
    chan_mask_t               ack;
    chan_mask_t               full;
    logic [DATAWIDTH_BUS-1:0] slot_data [CC_DEMUX_CHANNELS];

    assign clk   = CC_DEMUX_CLOCK_50;
    assign rst_n = CC_DEMUX_RESET_InLow;
    assign sel   = CC_DEMUX_selection_InBUS;

    // An X/Z select freezes the block: no write, no ack, no count.
    // Synthesis sees a constant 1 here; only simulation can observe the guard.
    assign sel_known = !$isunknown(sel);

    // NOTE: every signal written in this always_comb gets a default first, so no latch is inferred.
    always_comb begin
        CC_DEMUX_ready_Out = 1'b0;
        accept             = 1'b0;
        we                 = '0;
        ack                = '0;
        if (sel_known) begin
`ifdef CC_DEMUX_OVERWRITE_EN
            CC_DEMUX_ready_Out = 1'b1;
`else
            CC_DEMUX_ready_Out = ~full[sel] | CC_DEMUX_ack_InBUS[sel];
`endif
            accept = CC_DEMUX_valid_In & CC_DEMUX_ready_Out;
            we     = accept ? onehot_decode(sel) : '0;
            ack    = CC_DEMUX_ack_InBUS;
        end
    end

    for (genvar i = 0; i < CC_DEMUX_CHANNELS; i++) begin : g_slot
        cc_demux_channel_slot #(.DW(DATAWIDTH_BUS)) u_slot (
            .clk     (clk),
            .rst_n   (rst_n),
            .we      (we[i]),
            .ack     (ack[i]),
            .wr_data (CC_DEMUX_data_InBUS),
            .data    (slot_data[i]),
            .valid   (full[i])
        );
    end

    assign CC_DEMUX_data0_OutBUS = slot_data[0];
    assign CC_DEMUX_data1_OutBUS = slot_data[1];
    assign CC_DEMUX_data2_OutBUS = slot_data[2];
    assign CC_DEMUX_data3_OutBUS = slot_data[3];
    assign CC_DEMUX_data4_OutBUS = slot_data[4];
    assign CC_DEMUX_data5_OutBUS = slot_data[5];
    assign CC_DEMUX_data6_OutBUS = slot_data[6];
    assign CC_DEMUX_data7_OutBUS = slot_data[7];
    assign CC_DEMUX_valid_OutBUS = full;

    // Accepted-write counter; wraps silently.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            CC_DEMUX_count_OutBUS <= '0;
        end else if (accept) begin
            CC_DEMUX_count_OutBUS <= CC_DEMUX_count_OutBUS + 1'b1;
        end
    end

`ifdef CC_DEMUX_OVERWRITE_EN
    // Sticky: set when an accepted write lands on a full slot that is not being acked.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            CC_DEMUX_overflow_Out <= 1'b0;
        end else if (accept && full[sel] && !CC_DEMUX_ack_InBUS[sel]) begin
            CC_DEMUX_overflow_Out <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_cc_demux_channel_writer.sv
// Self-checking bench for cc_demux_channel_writer: a channel-table model checked every cycle
// plus directed literal expectations. Honours CC_DEMUX_OVERWRITE_EN when defined.
module tb_cc_demux_channel_writer;

    localparam int DW  = 8;
    localparam int SW  = 3;
    localparam int CW  = 8;
    localparam int NCH = 8;

    logic           clk = 1'b0;
    logic           rst_n;
    logic [DW-1:0]  wdata;
    logic [SW-1:0]  sel;
    logic           wvalid;
    logic           ready;
    logic [NCH-1:0] ack;
    logic [DW-1:0]  d0, d1, d2, d3, d4, d5, d6, d7;
    logic [NCH-1:0] vout;
    logic [CW-1:0]  cnt;
`ifdef CC_DEMUX_OVERWRITE_EN
    logic           ovf;
`endif

    always #5 clk = ~clk;

    cc_demux_channel_writer dut (
        .CC_DEMUX_CLOCK_50        (clk),
        .CC_DEMUX_RESET_InLow     (rst_n),
        .CC_DEMUX_data_InBUS      (wdata),
        .CC_DEMUX_selection_InBUS (sel),
        .CC_DEMUX_valid_In        (wvalid),
        .CC_DEMUX_ready_Out       (ready),
        .CC_DEMUX_ack_InBUS       (ack),
        .CC_DEMUX_data0_OutBUS    (d0),
        .CC_DEMUX_data1_OutBUS    (d1),
        .CC_DEMUX_data2_OutBUS    (d2),
        .CC_DEMUX_data3_OutBUS    (d3),
        .CC_DEMUX_data4_OutBUS    (d4),
        .CC_DEMUX_data5_OutBUS    (d5),
        .CC_DEMUX_data6_OutBUS    (d6),
        .CC_DEMUX_data7_OutBUS    (d7),
        .CC_DEMUX_valid_OutBUS    (vout),
`ifdef CC_DEMUX_OVERWRITE_EN
        .CC_DEMUX_overflow_Out    (ovf),
`endif
        .CC_DEMUX_count_OutBUS    (cnt)
    );

    logic [DW-1:0] dut_data [NCH];
    assign dut_data[0] = d0;
    assign dut_data[1] = d1;
    assign dut_data[2] = d2;
    assign dut_data[3] = d3;
    assign dut_data[4] = d4;
    assign dut_data[5] = d5;
    assign dut_data[6] = d6;
    assign dut_data[7] = d7;

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: a table of 8 channels, each a data byte plus a full bit, and an integer write tally.
    logic [DW-1:0]  m_data [NCH];
    logic [NCH-1:0] m_full;
    int unsigned    m_count;
    bit             m_ovf;
    bit             model_live = 1'b0;
    bit             m_acc;
    bit             m_clobber;

    function automatic bit model_ready();
`ifdef CC_DEMUX_OVERWRITE_EN
        return 1'b1;
`else
        return !m_full[sel] || ack[sel];
`endif
    endfunction

    always @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NCH; i++) m_data[i] = '0;
            m_full     = '0;
            m_count    = 0;
            m_ovf      = 1'b0;
            model_live = 1'b1;
        end else if (model_live) begin
            m_acc     = wvalid && model_ready();
            m_clobber = m_acc && m_full[sel] && !ack[sel];
            m_full    = m_full & ~ack;
            if (m_acc) begin
                m_data[sel] = wdata;
                m_full[sel] = 1'b1;
                m_count     = (m_count + 1) % (1 << CW);
            end
            if (m_clobber) m_ovf = 1'b1;
        end
    end

    // Compare every cycle on the falling edge, once the model has seen a reset.
    always @(negedge clk) begin
        if (model_live) begin
            for (int i = 0; i < NCH; i++)
                check($sformatf("cyc_data%0d", i), 32'(dut_data[i]), 32'(m_data[i]));
            check("cyc_valid", 32'(vout), 32'(m_full));
            check("cyc_count", 32'(cnt), m_count);
            check("cyc_ready", 32'(ready), 32'(model_ready()));
`ifdef CC_DEMUX_OVERWRITE_EN
            check("cyc_overflow", 32'(ovf), 32'(m_ovf));
`endif
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    initial begin
        // 1. Reset held two cycles with a pending write.
        rst_n  = 1'b0;
        wvalid = 1'b1;
        sel    = 3'd3;
        wdata  = 8'hFF;
        ack    = '0;
        step();
        step();
        check("rst_count", 32'(cnt), 32'd0);
        check("rst_valid", 32'(vout), 32'h00);
        check("rst_data3", 32'(d3), 32'h00);
        rst_n  = 1'b1;
        wvalid = 1'b0;
        step();

        // 2. Single write to channel 3.
        wvalid = 1'b1;
        sel    = 3'd3;
        wdata  = 8'hA5;
        #1 check("w1_ready", 32'(ready), 32'd1);
        step();
        wvalid = 1'b0;
        check("w1_data3", 32'(d3), 32'hA5);
        check("w1_valid", 32'(vout), 32'h08);
        check("w1_count", 32'(cnt), 32'd1);
        check("w1_data0", 32'(d0), 32'h00);

`ifndef CC_DEMUX_OVERWRITE_EN
        // 3a. Blocked write to the full channel 3.
        wvalid = 1'b1;
        wdata  = 8'h5A;
        #1 check("blk_ready", 32'(ready), 32'd0);
        step();
        check("blk_data3", 32'(d3), 32'hA5);
        check("blk_count", 32'(cnt), 32'd1);
`endif
        // 3b. Same-cycle ack lets the write through; write wins over ack.
        wvalid = 1'b1;
        sel    = 3'd3;
        wdata  = 8'h5A;
        ack    = 8'h08;
        #1 check("ackw_ready", 32'(ready), 32'd1);
        step();
        wvalid = 1'b0;
        ack    = '0;
        check("ackw_data3", 32'(d3), 32'h5A);
        check("ackw_valid", 32'(vout), 32'h08);
        check("ackw_count", 32'(cnt), 32'd2);

        // Free channel 3 so the sweep below is never blocked.
        ack = 8'h08;
        step();
        ack = '0;
        check("ack3_valid", 32'(vout), 32'h00);
        check("ack3_data3", 32'(d3), 32'h5A);

        // 4. Fill all channels, ack everything, then 256 more writes.
        for (int i = 0; i < NCH; i++) begin
            wvalid = 1'b1;
            sel    = 3'(i);
            wdata  = 8'(8'h10 + i);
            step();
        end
        wvalid = 1'b0;
        check("fill_valid", 32'(vout), 32'hFF);
        check("fill_count", 32'(cnt), 32'd10);
        ack = 8'hFF;
        step();
        ack = '0;
        check("drain_valid", 32'(vout), 32'h00);
        check("drain_data3", 32'(d3), 32'h13);
        check("drain_data7", 32'(d7), 32'h17);
        for (int i = 0; i < 256; i++) begin
            wvalid = 1'b1;
            sel    = 3'(i % NCH);
            wdata  = 8'(i);
            ack    = 8'hFF;
            step();
        end
        wvalid = 1'b0;
        step();
        ack = '0;
        check("wrap_count", 32'(cnt), 32'd10);
        check("wrap_valid", 32'(vout), 32'h00);
        check("wrap_data7", 32'(d7), 32'hFF);

        // 5. Reset overrides a write in the same cycle.
        rst_n  = 1'b0;
        wvalid = 1'b1;
        sel    = 3'd5;
        wdata  = 8'h77;
        step();
        rst_n  = 1'b1;
        wvalid = 1'b0;
        check("midrst_valid", 32'(vout), 32'h00);
        check("midrst_data5", 32'(d5), 32'h00);
        check("midrst_count", 32'(cnt), 32'd0);

`ifdef CC_DEMUX_OVERWRITE_EN
        // 6. Overwrite of a full, un-acked slot.
        wvalid = 1'b1;
        sel    = 3'd0;
        wdata  = 8'h11;
        step();
        wdata  = 8'h22;
        step();
        wvalid = 1'b0;
        check("ovw_data0", 32'(d0), 32'h22);
        check("ovw_overflow", 32'(ovf), 32'd1);
        check("ovw_count", 32'(cnt), 32'd2);
`endif

        step();
        step();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
